fifo_rd_chk: RTL

Read-side consumer and checker for the synchronous FIFO. It sits opposite the data generator: it drives `rd_en` into the FIFO in paced bursts, captures each word the FIFO returns, and compares it against the generator's sequence. The generator's sequence is an incrementing count that starts at 0 after reset and wraps at 2^WIDTH. The block reports read counts, mismatch pulses and a saturating error count, so the FIFO top can be self-checking in simulation and on the board.

---
 rtl/fifo_rd_chk_if.sv | 27 ++
 rtl/fifo_rd_chk.sv | 121 ++++++++++++
 2 files changed

// File: rtl/fifo_rd_chk_if.sv
// Read-side bundle between the FIFO and the read checker.
// The slave modport is the checker's view; master is the FIFO/environment side.
interface fifo_rd_chk_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic             empty;
    logic             full;
    logic [WIDTH-1:0] data_in;
    logic             rd_en;
    logic [WIDTH-1:0] data_out;
    logic             valid;
    logic             err;
    logic [15:0]      err_cnt;
    logic [15:0]      rd_cnt;
    logic             full_seen;

    modport slave (
        input  enable, empty, full, data_in,
        output rd_en, data_out, valid, err, err_cnt, rd_cnt, full_seen
    );

    modport master (
        output enable, empty, full, data_in,
        input  rd_en, data_out, valid, err, err_cnt, rd_cnt, full_seen
    );
endinterface

// File: rtl/fifo_rd_chk.sv
// FIFO read-side consumer: paced burst reads, sequence check against an
// incrementing count, with read/error counters and a sticky full flag.
module fifo_rd_chk #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 63,
    parameter int BURST_LEN = 16,
    parameter int PAUSE_LEN = 8
) (
    input  logic          clk,
    input  logic          rst,
    fifo_rd_chk_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_PAUSE
    } state_t;

    if (DEPTH < 1 || BURST_LEN < 1 || BURST_LEN > 65535 ||
        PAUSE_LEN < 1 || PAUSE_LEN > 65535) begin : g_bad_param
        $error("fifo_rd_chk: parameter out of range");
    end

    state_t           r_state;
    state_t           w_next;
    logic [15:0]      r_burst_cnt;
    logic [15:0]      r_pause_cnt;
    logic             r_pend;
    logic [WIDTH-1:0] r_expected;
    logic [WIDTH-1:0] r_data_out;
    logic             r_valid;
    logic             r_err;
    logic [15:0]      r_err_cnt;
    logic [15:0]      r_rd_cnt;
    logic             r_full_seen;

    logic             w_rd_en;
    logic             w_fire;
    logic             w_burst_last;
    logic             w_pause_last;
    logic             w_match;

    // Gated by rst so no read escapes while the FSM is being forced to IDLE
    assign w_rd_en      = (r_state == S_DRAIN) & bus.enable & ~bus.empty & ~rst;
    assign w_fire       = w_rd_en;
    assign w_burst_last = (r_burst_cnt == 16'(BURST_LEN - 1));
    assign w_pause_last = (r_pause_cnt == 16'(PAUSE_LEN - 1));
    assign w_match      = (bus.data_in == r_expected);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.enable) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (!bus.enable)
                    w_next = S_IDLE;
                else if (w_fire && w_burst_last)
                    w_next = S_PAUSE;
            end
            S_PAUSE: begin
                if (!bus.enable)
                    w_next = S_IDLE;
                else if (w_pause_last)
                    w_next = S_DRAIN;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_burst_cnt <= '0;
            r_pause_cnt <= '0;
            r_pend      <= 1'b0;
            r_expected  <= '0;
            r_data_out  <= '0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
            r_err_cnt   <= '0;
            r_rd_cnt    <= '0;
            r_full_seen <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_pend      <= w_fire;
            r_full_seen <= r_full_seen | bus.full;

            if (!bus.enable) begin
                r_burst_cnt <= '0;
                r_pause_cnt <= '0;
            end else begin
                if (w_fire)
                    r_burst_cnt <= w_burst_last ? 16'd0 : r_burst_cnt + 16'd1;
                if (r_state == S_PAUSE)
                    r_pause_cnt <= w_pause_last ? 16'd0 : r_pause_cnt + 16'd1;
            end

            // Capture is driven only by pend, so an in-flight word survives
            // enable dropping or the FSM leaving DRAIN.
            r_valid <= r_pend;
            r_err   <= r_pend & ~w_match;
            if (r_pend) begin
                r_data_out <= bus.data_in;
                r_rd_cnt   <= r_rd_cnt + 16'd1;
                r_expected <= bus.data_in + WIDTH'(1);
                if (!w_match && r_err_cnt != 16'hFFFF)
                    r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign bus.rd_en     = w_rd_en;
    assign bus.data_out  = r_data_out;
    assign bus.valid     = r_valid;
    assign bus.err       = r_err;
    assign bus.err_cnt   = r_err_cnt;
    assign bus.rd_cnt    = r_rd_cnt;
    assign bus.full_seen = r_full_seen;
endmodule
